// File: rtl/program_counter.sv
// Purpose : 10-bit CPU fetch address register with redirect, halt, sticky wrap and optional return stack.
// Latency : all outputs registered; redirect (load/ret) visible one cycle after the request.
// Backpr. : pc is offered with pc_valid and holds stable until pc_ready; load/ret discard the offered pc.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   pc / pc_valid         fetch address and its valid qualifier
//   pc_ready              instruction memory accepts pc this cycle
//   load / load_addr      redirect to load_addr (call marks it as a subroutine call)
//   call / ret            push return address on load / pop into pc
//   halt                  stop fetching until load (or ret with the stack built in)
//   wrapped               sticky: pc advanced 1023 -> 0
//   stack_err             sticky: ret on an empty return stack
//
// Build option: define PC_CALL_STACK_EN to include the STACK_DEPTH-entry return-address stack.

module ten_bit_incrementer (
  input  logic [9:0] a,
  output logic [9:0] sum,
  output logic       carry
);
  assign {carry, sum} = {1'b0, a} + 11'd1;
endmodule

module program_counter #(
  parameter logic [9:0] RESET_ADDR  = 10'd0,
  parameter int         STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] pc,
  output logic       pc_valid,
  input  logic       pc_ready,
  input  logic       load,
  input  logic [9:0] load_addr,
  input  logic       call,
  input  logic       ret,
  input  logic       halt,
  output logic       wrapped,
  output logic       stack_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [9:0] pc_inc;
  logic       inc_co;

  logic [9:0] pc_nxt;
  logic       pc_valid_nxt;
  logic       wrapped_nxt;
  logic       err_set;
  logic       do_push;
  logic       do_pop;

  // Stack view shared by both builds; without the stack, ret/call are
  // forced inactive so the FSM and datapath treat them as absent.
  logic       ret_en;
  logic       call_en;
  logic       stk_empty;
  logic [9:0] stk_top;

  ten_bit_incrementer u_inc (
    .a     (pc),
    .sum   (pc_inc),
    .carry (inc_co)
  );

  // ---------------------------------------------------------------------------
  // Return-address stack
  // ---------------------------------------------------------------------------
`ifdef PC_CALL_STACK_EN
  localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_W:0] STK_FULL = (PTR_W + 1)'(STACK_DEPTH);

  logic [9:0]       stk_mem [STACK_DEPTH];
  logic [PTR_W-1:0] stk_wp;     // next slot to write; top of stack is stk_wp-1
  logic [PTR_W:0]   stk_cnt;
  logic [PTR_W-1:0] stk_top_idx;

  assign ret_en      = ret;
  assign call_en     = call;
  assign stk_empty   = (stk_cnt == '0);
  assign stk_top_idx = stk_wp - PTR_W'(1);
  assign stk_top     = stk_mem[stk_top_idx];

  // Circular write pointer: pushing when full silently overwrites the oldest
  // entry because the pointer simply wraps onto it; the count saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stk_wp  <= '0;
      stk_cnt <= '0;
    end else if (do_push) begin
      stk_wp <= stk_wp + PTR_W'(1);
      if (stk_cnt != STK_FULL) begin
        stk_cnt <= stk_cnt + (PTR_W + 1)'(1);
      end
    end else if (do_pop) begin
      stk_wp  <= stk_wp - PTR_W'(1);
      stk_cnt <= stk_cnt - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      stk_mem[stk_wp] <= pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stack_err <= 1'b0;
    end else if (err_set) begin
      stack_err <= 1'b1;
    end
  end
`else
  logic unused_stack;

  assign ret_en    = 1'b0;
  assign call_en   = 1'b0;
  assign stk_empty = 1'b1;
  assign stk_top   = '0;
  assign stack_err = 1'b0;

  assign unused_stack = &{1'b0, call, ret, do_push, do_pop, err_set, (STACK_DEPTH > 0)};
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        state_nxt = RUN;
      end
      RUN: begin
        // load and ret outrank halt, so halt only takes effect when neither is active
        if (!load && !ret_en && halt) begin
          state_nxt = HALTED;
        end
      end
      HALTED: begin
        if (load || (ret_en && !stk_empty)) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath actions
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_nxt      = pc;
    wrapped_nxt = wrapped;
    err_set     = 1'b0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    case (state)
      RUN: begin
        if (load) begin
          pc_nxt  = load_addr;
          do_push = call_en;
        end else if (ret_en) begin
          if (!stk_empty) begin
            pc_nxt = stk_top;
            do_pop = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end else if (halt) begin
          pc_nxt = pc;
        end else if (pc_ready) begin
          // pc_valid is 1 throughout RUN, so pc_ready alone marks a transfer
          pc_nxt = pc_inc;
          if (inc_co) begin
            wrapped_nxt = 1'b1;
          end
        end
      end
      HALTED: begin
        if (load) begin
          pc_nxt  = load_addr;
          do_push = call_en;
        end else if (ret_en) begin
          if (!stk_empty) begin
            pc_nxt = stk_top;
            do_pop = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: begin
        pc_nxt = pc;
      end
    endcase
    pc_valid_nxt = (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_ADDR;
      pc_valid <= 1'b0;
      wrapped  <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      pc_valid <= pc_valid_nxt;
      wrapped  <= wrapped_nxt;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// Purpose : randomized + directed scoreboard bench for program_counter.
// Latency : expected outputs are queued one per cycle and compared on the falling edge.
// Backpr. : pc_ready is driven randomly to exercise hold-while-stalled behaviour.

module tb_program_counter;

`ifdef PC_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pc;
  logic       pc_valid;
  logic       pc_ready = 1'b0;
  logic       load = 1'b0;
  logic [9:0] load_addr = '0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic       halt = 1'b0;
  logic       wrapped;
  logic       stack_err;

  always #5 clk = ~clk;

  program_counter #(.RESET_ADDR(10'd0), .STACK_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .pc_ready  (pc_ready),
    .load      (load),
    .load_addr (load_addr),
    .call      (call),
    .ret       (ret),
    .halt      (halt),
    .wrapped   (wrapped),
    .stack_err (stack_err)
  );

  typedef struct {
    logic       v;
    logic [9:0] a;
    logic       w;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: spec-level behaviour with the return stack as a queue.
  bit   m_known = 1'b0;
  int   m_phase = 0;   // 0 idle, 1 running, 2 halted
  int   m_pc    = 0;
  bit   m_wrap  = 1'b0;
  bit   m_err   = 1'b0;
  int   m_stk[$];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: pop one expected snapshot per cycle and compare with the DUT.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t ex;
      ex = exp_q.pop_front();
      check("pc_valid", int'(pc_valid), int'(ex.v));
      check("pc", int'(pc), int'(ex.a));
      check("wrapped", int'(wrapped), int'(ex.w));
      check("stack_err", int'(stack_err), int'(ex.e));
    end
  end

  task automatic model_ret(input bit leave_halt);
    if (m_stk.size() > 0) begin
      m_pc = m_stk.pop_back();
      if (leave_halt) m_phase = 1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic model_load(input int la, input logic c);
    if (c && STK) begin
      m_stk.push_back((m_pc + 1) % 1024);
      if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
    end
    m_pc = la;
    m_phase = 1;
  endtask

  // One clock cycle: record what the DUT should show now, drive the inputs
  // for the coming edge, then advance the model across that edge.
  task automatic cyc(input logic r, input logic ld, input int la, input logic c,
                     input logic rt, input logic h, input logic rdy);
    exp_t ex;
    @(posedge clk);
    #1;
    if (m_known) begin
      ex.v = (m_phase == 1);
      ex.a = 10'(m_pc);
      ex.w = m_wrap;
      ex.e = m_err;
      exp_q.push_back(ex);
    end
    rst_n     = r;
    load      = ld;
    load_addr = 10'(la);
    call      = c;
    ret       = rt;
    halt      = h;
    pc_ready  = rdy;
    if (!r) begin
      m_known = 1'b1;
      m_phase = 0;
      m_pc    = 0;
      m_wrap  = 1'b0;
      m_err   = 1'b0;
      m_stk.delete();
    end else if (m_known) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (ld)              model_load(la, c);
        else if (rt && STK)  model_ret(1'b0);
        else if (h)          m_phase = 2;
        else if (rdy) begin
          if (m_pc == 1023) begin
            m_pc   = 0;
            m_wrap = 1'b1;
          end else begin
            m_pc = m_pc + 1;
          end
        end
      end else begin
        if (ld)              model_load(la, c);
        else if (rt && STK)  model_ret(1'b1);
      end
    end
  endtask

  // Shorthands for the directed sequences
  task automatic idle_cyc(input logic rdy);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, rdy);
  endtask

  task automatic jump(input int la, input logic c, input logic rdy);
    cyc(1'b1, 1'b1, la, c, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    // reset, release, fetch 0,1,2
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle_cyc(1'b1);

    // stall at 5 for four cycles, then advance to 6
    jump(5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle_cyc(1'b0);
    idle_cyc(1'b1);
    idle_cyc(1'b0);

    // wrap 1022 -> 1023 -> 0
    jump(1022, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) idle_cyc(1'b1);

    // redirect to 300 while stalled, halt, pc_ready activity, resume via load 40
    jump(12, 1'b0, 1'b1);
    jump(300, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_cyc(1'b1);
    idle_cyc(1'b0);
    idle_cyc(1'b1);
    jump(40, 1'b0, 1'b1);
    idle_cyc(1'b1);
    idle_cyc(1'b1);

    // call/return nesting and underflow
    jump(20, 1'b0, 1'b0);
    jump(500, 1'b1, 1'b1);
    jump(700, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_cyc(1'b0);
    idle_cyc(1'b1);

    // stack overflow: five nested calls, then unwind
    for (int i = 0; i < 5; i++) jump(100 * (i + 1), 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1);

    // reset while halted
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cyc(1'b1);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle_cyc(1'b1);
    idle_cyc(1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, ld, c, rt, h, rdy;
      int   la;
      r   = ($urandom_range(199, 0) != 0);
      ld  = ($urandom_range(9, 0) == 0);
      la  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(1023, 1018))
                                        : int'($urandom_range(1023, 0));
      c   = $urandom_range(1, 0) == 1;
      rt  = ($urandom_range(11, 0) == 0);
      h   = ($urandom_range(19, 0) == 0);
      rdy = ($urandom_range(9, 0) < 7);
      cyc(r, ld, la, c, rt, h, rdy);
    end

    // final snapshot after the last edge, then drain
    idle_cyc(1'b0);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/program_counter.md
# program_counter

Holds the CPU's 10-bit fetch address and offers it to instruction memory with a valid/ready handshake. It sits directly downstream of `ten_bit_incrementer` and consumes its sum and carry to advance sequentially. Branch/jump redirects, halting and sticky wrap detection are handled here. An optional return-address stack is compiled in with a macro.

## Interface
Parameters:
- RESET_ADDR, 10'd0, PC value loaded on reset
- STACK_DEPTH, 4, return-stack entries (power of two, 2..16; used only with `PC_CALL_STACK_EN`)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- pc  out  10  current fetch address
- pc_valid  out  1  pc is offered to memory
- pc_ready  in  1  memory accepts pc this cycle
- load  in  1  redirect request (branch taken / jump)
- load_addr  in  10  redirect target
- call  in  1  qualifies load as a call (push return address)
- ret  in  1  return: pop stack into pc
- halt  in  1  stop fetching
- wrapped  out  1  sticky: pc advanced 1023 -> 0
- stack_err  out  1  sticky: pop on empty stack

## Operation
- Internal instance of `ten_bit_incrementer`: a = pc, sum = pc_inc, carry = inc_co.
- States: IDLE, RUN, HALTED.
  - IDLE: entered on reset; pc_valid = 0; goes to RUN unconditionally next cycle.
  - RUN: pc_valid = 1.
  - HALTED: pc_valid = 0; pc frozen; leaves only on load or ret, back to RUN, or on reset.
- Handshake: xfer = pc_valid & pc_ready. While pc_valid = 1 and no xfer, pc holds stable.
- Per-cycle priority in RUN, highest first:
  - load: pc <= load_addr regardless of pc_ready; the offered address is discarded; state stays RUN.
  - ret: pc <= top of stack (see Configuration); state stays RUN.
  - halt: state -> HALTED; pc unchanged.
  - xfer: pc <= pc_inc; if inc_co = 1, then pc = 0 and wrapped <= 1.
  - Otherwise: hold.
- load and ret in the same cycle: load wins; ret is ignored and no pop occurs.
- call without load: ignored.
- load/ret/halt in IDLE: ignored.
- wrapped and stack_err are cleared only by reset.

## Timing
- Reset (rst_n = 0 at an edge): pc = RESET_ADDR, pc_valid = 0, state IDLE, wrapped = 0, stack_err = 0, stack empty.
- First edge with rst_n = 1 moves to RUN; pc_valid = 1 from the following cycle.
- All outputs are registered.
- Redirect latency: 1 cycle; the new pc is visible the cycle after load.
- Sustained fetch: 1 address per cycle while pc_ready = 1.
- Reset asserted mid-stall or in HALTED: reset behaviour above applies immediately at that edge; pending stack contents are lost.

## Configuration
- Macro: `PC_CALL_STACK_EN`.
- Defined: STACK_DEPTH-entry LIFO.
  - load & call pushes the return address (pc_inc of the current pc) and jumps to load_addr.
  - Push when full overwrites the oldest entry (circular) with no error.
  - ret pops the top entry into pc.
  - ret on empty: pc unchanged, stack_err <= 1, state stays RUN.
  - ret in HALTED pops and resumes RUN.
- Undefined: no stack storage.
  - call and ret are ignored; ret does not leave HALTED.
  - stack_err is tied 0.

## Test plan
- Reset, then pc_ready = 1 for 3 cycles -> pc_valid rises 2 cycles after reset release; pc = 0, 1, 2 on successive cycles.
- pc = 5, pc_ready = 0 for 4 cycles -> pc stays 5 and pc_valid stays 1; on pc_ready = 1, the next cycle shows 6.
- pc = 1022, pc_ready = 1 held -> pc = 1023, then 0 with wrapped = 1; wrapped stays 1 until reset.
- At pc = 12: load = 1, load_addr = 300, pc_ready = 0 -> pc = 300 next cycle. Then halt = 1 -> pc_valid = 0 and pc stays 300 through any pc_ready activity; load_addr = 40 -> RUN with pc = 40.
- With `PC_CALL_STACK_EN`:
  - At pc = 20: call to 500, then call to 700, then ret, then ret -> pc sequence 500, 700, 501, 21.
  - A further ret -> pc holds and stack_err = 1.
- Without `PC_CALL_STACK_EN`: the same call/ret stimulus -> pc = 500, 700, then increments; stack_err stays 0.
